// File: rtl/seq_stepper.sv
// seq_stepper: registered up/down sequencer over a programmable cyclic table.
// Index, direction and wrap pulse are flops; the table value is a combinational
// lookup of the registered index. Supports wrap and bounce modes, a clamped
// synchronous index load, and an asynchronous active-high reset.
module seq_stepper #(
    parameter int                         STEPS      = 6,
    parameter int                         VAL_W      = 3,
    parameter logic [STEPS*VAL_W-1:0]     SEQ_VALUES = 18'o265333,
    localparam int                        IDX_W      = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             down,
    input  logic             mode_bounce,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    output logic [IDX_W-1:0] idx,
    output logic [VAL_W-1:0] value,
    output logic             dir,
    output logic             wrap
);

    // Table end points and the indices a bounce lands on after reversing.
    // With a single entry every move lands back on index 0.
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(STEPS - 1);
    localparam logic [IDX_W-1:0] BOUNCE_HI = (STEPS > 1) ? IDX_W'(STEPS - 2) : '0;
    localparam logic [IDX_W-1:0] BOUNCE_LO = (STEPS > 1) ? IDX_W'(1) : '0;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;

    logic             at_last;
    logic             at_first;

    assign at_last  = (idx_q == LAST_IDX);
    assign at_first = (idx_q == '0);

    // Next-state selection: load beats step, step beats hold.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        idx_d  = idx_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;

        if (load) begin
            // Clamp out-of-range codes so idx never holds an unreachable value.
            idx_d = (load_idx > LAST_IDX) ? LAST_IDX : load_idx;
        end else if (step) begin
            if (!mode_bounce) begin
                // Wrap mode: the direction input drives this move and is recorded.
                dir_d = down;
                if (!down) begin
                    if (at_last) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    if (at_first) begin
                        idx_d  = LAST_IDX;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end else begin
                // Bounce mode: the stored direction decides; reverse at the ends.
                if (!dir_q) begin
                    if (at_last) begin
                        idx_d  = BOUNCE_HI;
                        dir_d  = 1'b1;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    if (at_first) begin
                        idx_d  = BOUNCE_LO;
                        dir_d  = 1'b0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update
        // together from values sampled at the same edge.
        if (reset) begin
            idx_q  <= '0;
            dir_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
        end
    end

    // Table lookup of the registered index; no added latency.
    always_comb begin
        value = '0;
        for (int i = 0; i < STEPS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                value = SEQ_VALUES[i*VAL_W +: VAL_W];
            end
        end
    end

    assign idx  = idx_q;
    assign dir  = dir_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_seq_stepper.sv
// Testbench for seq_stepper: reset checks, a vector table covering the wrap,
// bounce, load and mode-switch sequences, hand-written hold and async-reset
// sequences, and a randomized run against a behavioural reference model.
module tb_seq_stepper;

    localparam int STEPS = 6;
    localparam int VAL_W = 3;
    localparam int IDX_W = 3;

    logic             clk;
    logic             reset;
    logic             step;
    logic             down;
    logic             mode_bounce;
    logic             load;
    logic [IDX_W-1:0] load_idx;
    logic [IDX_W-1:0] idx;
    logic [VAL_W-1:0] value;
    logic             dir;
    logic             wrap;

    int checks;
    int errors;

    // Default table contents as listed for the block: 3,3,3,5,6,2.
    int vals [STEPS] = '{3, 3, 3, 5, 6, 2};

    seq_stepper dut (
        .clk         (clk),
        .reset       (reset),
        .step        (step),
        .down        (down),
        .mode_bounce (mode_bounce),
        .load        (load),
        .load_idx    (load_idx),
        .idx         (idx),
        .value       (value),
        .dir         (dir),
        .wrap        (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       step;
        logic       down;
        logic       mode_bounce;
        logic       load;
        logic [2:0] load_idx;
        int         exp_idx;
        int         exp_value;
        int         exp_dir;
        int         exp_wrap;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int e_idx, input int e_val,
                             input int e_dir, input int e_wrap);
        check({tag, ".idx"},   int'(idx),   e_idx);
        check({tag, ".value"}, int'(value), e_val);
        check({tag, ".dir"},   int'(dir),   e_dir);
        check({tag, ".wrap"},  int'(wrap),  e_wrap);
    endtask

    task automatic drive(input logic s, input logic d, input logic mb,
                         input logic l, input logic [2:0] li);
        step        = s;
        down        = d;
        mode_bounce = mb;
        load        = l;
        load_idx    = li;
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(input logic s, input logic d, input logic mb,
                               input logic l, input logic [2:0] li,
                               input int ei, input int ev, input int ed, input int ew);
        vec_t r;
        r.step = s; r.down = d; r.mode_bounce = mb; r.load = l; r.load_idx = li;
        r.exp_idx = ei; r.exp_value = ev; r.exp_dir = ed; r.exp_wrap = ew;
        return r;
    endfunction

    // Reference model state: plain integer index and direction.
    int m_idx;
    int m_dir;
    int m_wrap;

    // One clock edge of the sequencer described in terms of table positions.
    task automatic model_edge(input bit s, input bit d, input bit mb,
                              input bit l, input int li);
        int raw;
        m_wrap = 0;
        if (l) begin
            m_idx = (li > STEPS - 1) ? STEPS - 1 : li;
        end else if (s) begin
            if (!mb) begin
                m_dir  = d;
                raw    = m_idx + (d ? -1 : 1);
                m_wrap = (raw < 0 || raw >= STEPS) ? 1 : 0;
                m_idx  = (raw + STEPS) % STEPS;
            end else begin
                raw = m_idx + (m_dir ? -1 : 1);
                if (raw < 0 || raw >= STEPS) begin
                    m_dir  = 1 - m_dir;
                    m_wrap = 1;
                    raw    = m_idx + (m_dir ? -1 : 1);
                end
                m_idx = raw;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(0, 0, 0, 0, 3'd0);

        // Reset asserted from time zero: outputs must be cleared before any edge.
        reset = 1'b1;
        #2;
        check_all("reset_no_clock", 0, 3, 0, 0);
        tick();
        reset = 1'b0;

        // Vector table: each row is applied for one edge, then compared.
        // Wrap up through the whole table.
        vecs.push_back(v(1, 0, 0, 0, 0, 1, 3, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 2, 3, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 3, 5, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 4, 6, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 5, 2, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 3, 0, 1));
        // Wrap down from 0.
        vecs.push_back(v(1, 1, 0, 0, 0, 5, 2, 1, 1));
        vecs.push_back(v(1, 1, 0, 0, 0, 4, 6, 1, 0));
        // Load beats step, and an out-of-range code clamps; dir unchanged.
        vecs.push_back(v(1, 0, 0, 1, 7, 5, 2, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 3, 3, 5, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 3, 5, 1, 0));
        // Wrap step up to clear dir before bounce.
        vecs.push_back(v(1, 0, 0, 0, 0, 4, 6, 0, 0));
        // Bounce: load 4 then three steps, reversing at the top.
        vecs.push_back(v(0, 0, 1, 1, 4, 4, 6, 0, 0));
        vecs.push_back(v(1, 0, 1, 0, 0, 5, 2, 0, 0));
        vecs.push_back(v(1, 0, 1, 0, 0, 4, 6, 1, 1));
        vecs.push_back(v(1, 0, 1, 0, 0, 3, 5, 1, 0));
        // Bounce: load 1 then two steps, reversing at the bottom.
        vecs.push_back(v(0, 0, 1, 1, 1, 1, 3, 1, 0));
        vecs.push_back(v(1, 0, 1, 0, 0, 0, 3, 1, 0));
        vecs.push_back(v(1, 0, 1, 0, 0, 1, 3, 0, 1));
        // Bounce ignores the down input.
        vecs.push_back(v(1, 1, 1, 0, 0, 2, 3, 0, 0));
        // Back to wrap mode, down input drives direction again.
        vecs.push_back(v(1, 1, 0, 0, 0, 1, 3, 1, 0));
        // Entering bounce keeps the current dir (1): moves down.
        vecs.push_back(v(1, 0, 1, 0, 0, 0, 3, 1, 0));
        vecs.push_back(v(1, 0, 1, 0, 0, 1, 3, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].step, vecs[i].down, vecs[i].mode_bounce,
                  vecs[i].load, vecs[i].load_idx);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].exp_idx, vecs[i].exp_value,
                      vecs[i].exp_dir, vecs[i].exp_wrap);
        end

        // Hold at index 3 for ten cycles.
        drive(0, 0, 0, 1, 3'd3);
        tick();
        drive(0, 0, 0, 0, 3'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check(  $sformatf("hold%0d.idx", i),   int'(idx),   3);
            check(  $sformatf("hold%0d.value", i), int'(value), 5);
            check(  $sformatf("hold%0d.wrap", i),  int'(wrap),  0);
        end

        // Async reset mid-run at index 4 with dir=1.
        drive(0, 0, 0, 1, 3'd5);
        tick();
        drive(1, 1, 0, 0, 3'd0);
        tick();
        check_all("pre_reset", 4, 6, 1, 0);
        drive(1, 0, 0, 0, 3'd0);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 0, 3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("reset_held%0d", i), 0, 3, 0, 0);
        end
        reset = 1'b0;
        tick();
        check_all("first_step_after_reset", 1, 3, 0, 0);

        // Randomized run against the reference model.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_idx = 0; m_dir = 0; m_wrap = 0;
        for (int i = 0; i < 400; i++) begin
            bit s, d, mb, l;
            int li;
            s  = ($urandom_range(0, 3) != 0);
            d  = $urandom_range(0, 1);
            mb = ($urandom_range(0, 7) < 3);
            l  = ($urandom_range(0, 9) == 0);
            li = $urandom_range(0, 7);
            drive(s, d, mb, l, 3'(li));
            model_edge(s, d, mb, l, li);
            tick();
            check_all($sformatf("rand%0d", i), m_idx, vals[m_idx], m_dir, m_wrap);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
